// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read stage: FSM state encoding,
// output buffer depth and derived counter widths.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } rd_state_e;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1);

  // Wide enough for the largest legal load value, RD_LAT-1 = 6.
  localparam int unsigned CNT_W     = 3;

endpackage

// File: rtl/out_skid_buf.sv
// Two-entry in-order output buffer: entry 0 is always the head (oldest) word;
// a pop shifts entry 1 down, a push writes the first free slot.
module out_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_W-1:0]      occupancy,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] entry_q [BUF_DEPTH];
  logic [OCC_W-1:0]      occ_q;
  logic                  do_pop;

  // A pop request against an empty buffer is a no-op.
  assign do_pop = pop && (occ_q != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q   <= '0;
      // NOTE: the data entries are reset too, because the head entry is
      // visible on out_data and must read as zero while reset is asserted.
      entry_q <= '{default: '0};
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          entry_q[occ_q[0]] <= push_data;
          occ_q             <= occ_q + OCC_ONE;
        end
        2'b01: begin
          entry_q[0] <= entry_q[1];
          occ_q      <= occ_q - OCC_ONE;
        end
        2'b11: begin
          if (occ_q == OCC_ONE) begin
            entry_q[0] <= push_data;
          end else begin
            entry_q[0] <= entry_q[1];
            entry_q[1] <= push_data;
          end
        end
        default: ;
      endcase
      // The read FSM never issues into a full buffer, so a lone push when full
      // would mean a lost word.
      assert (!(push && !do_pop && (occ_q == OCC_FULL)))
        else $error("out_skid_buf: push into a full buffer");
    end
  end

  assign occupancy = occ_q;
  assign head_data = entry_q[0];

endmodule

// File: rtl/fifo_read_stage.sv
// Read stage between a FIFO controller with fixed-latency RAM and a
// valid/ready consumer. Define FIFO_READ_STAGE_STATS_EN to add xfer_count.
module fifo_read_stage
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  read,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy
`ifdef FIFO_READ_STAGE_STATS_EN
  ,
  output logic [15:0]           xfer_count
`endif
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RD_LAT - 1);
  localparam logic [OCC_W:0]   COMMIT_MAX = (OCC_W + 1)'(BUF_DEPTH);

  rd_state_e        state_q;
  logic [CNT_W-1:0] lat_cnt_q;
  logic             started_q;
  logic             read_q;
  logic             busy_q;

  logic [OCC_W-1:0] occupancy;
  logic             in_flight;
  logic [OCC_W:0]   committed;
  logic             capture;
  logic             transfer;

  // Words already buffered plus the one on its way must leave room for it.
  assign in_flight = (state_q != IDLE);
  assign committed = {1'b0, occupancy} + {{OCC_W{1'b0}}, in_flight};
  assign capture   = (state_q == WAIT) && (lat_cnt_q == '0);
  assign transfer  = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      started_q <= 1'b0;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      // started_q holds off the first read until the second edge after reset.
      started_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (started_q && !empty && (committed < COMMIT_MAX)) begin
            state_q <= ISSUE;
            read_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          state_q   <= WAIT;
          read_q    <= 1'b0;
          lat_cnt_q <= LAT_INIT;
        end
        WAIT: begin
          if (lat_cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            lat_cnt_q <= lat_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  out_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (capture),
    .push_data (rd_data),
    .pop       (transfer),
    .occupancy (occupancy),
    .head_data (out_data)
  );

  assign out_valid = (occupancy != '0);
  assign read      = read_q;
  assign busy      = busy_q;

`ifdef FIFO_READ_STAGE_STATS_EN
  logic [15:0] xfer_count_q;

  // Free-running; wraps from 0xFFFF back to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_count_q <= '0;
    end else if (transfer) begin
      xfer_count_q <= xfer_count_q + 16'd1;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule
